// File: rtl/bayer_video_pkg.sv
// Shared definitions for the Bayer video send/receive stages: FSM states, default geometry
// and the keep-mask width helper.
package bayer_video_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  localparam int PIXEL_W_DEF  = 8;
  localparam int PPC_DEF      = 2;
  localparam int MAX_ROWS_DEF = 4320;
  localparam int MAX_COLS_DEF = 3848;
  localparam int DIM_W_DEF    = 13;

  // Sub-byte pixels still get one keep bit so TKEEP is never zero-width.
  function automatic int keep_width(input int pixel_w, input int ppc);
    return (pixel_w * ppc / 8 < 1) ? 1 : pixel_w * ppc / 8;
  endfunction

endpackage

// File: rtl/bayer_mat_to_axis_video_if.sv
// Pixel-beat input stream plus AXI4-Stream video output; master is the converter side,
// slave is the producer/sink side.
interface bayer_mat_to_axis_video_if #(
  parameter int PIXEL_W = 8,
  parameter int PPC     = 2
);
  import bayer_video_pkg::*;

  localparam int DATA_W = PIXEL_W * PPC;
  localparam int KEEP_W = keep_width(PIXEL_W, PPC);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;

  modport master (
    input  in_data, in_valid, m_axis_tready,
    output in_ready, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    output in_data, in_valid, m_axis_tready,
    input  in_ready, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid
  );

endinterface

// File: rtl/bayer_mat_to_axis_video_axis_out_reg.sv
// Single-stage AXI4-Stream output register; a loaded beat is held until tready, and
// upstream may load whenever the stage is empty or draining this cycle.
module axis_out_reg #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic [KEEP_W-1:0] keep,
  input  logic              user,
  input  logic              last,
  input  logic              tready,
  output logic              ready,
  output logic [DATA_W-1:0] tdata,
  output logic [KEEP_W-1:0] tkeep,
  output logic              tuser,
  output logic              tlast,
  output logic              tvalid
);

  assign ready = !tvalid || tready;

  // Reset wins over the hold rule: a pending beat is discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      tdata  <= '0;
      tkeep  <= '0;
      tuser  <= 1'b0;
      tlast  <= 1'b0;
      tvalid <= 1'b0;
    end else if (load) begin
      tdata  <= data;
      tkeep  <= keep;
      tuser  <= user;
      tlast  <= last;
      tvalid <= 1'b1;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/bayer_mat_to_axis_video.sv
// Frames a raster pixel-beat stream as AXI4-Stream video (TUSER = SOF, TLAST = EOL); one cycle
// of latency, in_ready follows the output register, and dimensions are range-checked on start.
module bayer_mat_to_axis_video
  import bayer_video_pkg::*;
#(
  parameter int PIXEL_W  = PIXEL_W_DEF,
  parameter int PPC      = PPC_DEF,
  parameter int MAX_ROWS = MAX_ROWS_DEF,
  parameter int MAX_COLS = MAX_COLS_DEF,
  parameter int DIM_W    = DIM_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] rows,
  input  logic [DIM_W-1:0] cols,
  output logic             idle,
  output logic             done,
  output logic             err,
  output logic             stall_in,
  output logic             stall_out,
  bayer_mat_to_axis_video_if.master vid
);

  localparam int DATA_W = PIXEL_W * PPC;
  localparam int KEEP_W = keep_width(PIXEL_W, PPC);
  localparam logic [DIM_W-1:0] MAX_ROWS_V = DIM_W'(MAX_ROWS);
  localparam logic [DIM_W-1:0] MAX_COLS_V = DIM_W'(MAX_COLS);

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  rows_q, bpl_q, row_cnt, col_cnt, bpl_next;
  logic [DIM_W:0]    bpl_wide;
  logic [KEEP_W-1:0] last_keep_q, keep_calc, beat_keep;
  logic              err_q, dims_zero, dims_big, out_ready, accept, last_col, last_row;
  int                rem;

  assign dims_zero = (rows == '0) || (cols == '0);
  assign dims_big  = (rows > MAX_ROWS_V) || (cols > MAX_COLS_V);
  assign bpl_wide  = ({1'b0, cols} + (DIM_W+1)'(PPC - 1)) / (DIM_W+1)'(PPC);
  assign bpl_next  = bpl_wide[DIM_W-1:0];
  assign last_col  = (col_cnt == bpl_q - DIM_W'(1));
  assign last_row  = (row_cnt == rows_q - DIM_W'(1));
  assign accept    = vid.in_valid && vid.in_ready;
  assign beat_keep = last_col ? last_keep_q : '1;

  // Partial last beat keeps only the bytes holding the leftover pixels.
  always_comb begin
    rem       = int'({1'b0, cols} % (DIM_W+1)'(PPC));
    keep_calc = '1;
    if (PIXEL_W >= 8 && rem != 0)
      keep_calc = KEEP_W'((1 << (rem * PIXEL_W / 8)) - 1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      bpl_q       <= '0;
      last_keep_q <= '0;
      err_q       <= 1'b0;
      row_cnt     <= '0;
      col_cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        rows_q      <= rows;
        bpl_q       <= bpl_next;
        last_keep_q <= keep_calc;
        err_q       <= dims_big && !dims_zero;
        row_cnt     <= '0;
        col_cnt     <= '0;
      end else if (accept) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + DIM_W'(1);
        end else begin
          col_cnt <= col_cnt + DIM_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idle         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    vid.in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        idle = 1'b1;
        if (start) state_d = (dims_zero || dims_big) ? DONE : STREAM;
      end
      STREAM: begin
        vid.in_ready = out_ready;
        if (accept && last_col && last_row) state_d = FLUSH;
      end
      FLUSH: begin
        if (vid.m_axis_tvalid && vid.m_axis_tready) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_in  = vid.in_ready && !vid.in_valid;
  assign stall_out = vid.m_axis_tvalid && !vid.m_axis_tready;

  axis_out_reg #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) u_out (
    .clock  (clock),
    .reset  (reset),
    .load   (accept),
    .data   (vid.in_data),
    .keep   (beat_keep),
    .user   ((row_cnt == '0) && (col_cnt == '0)),
    .last   (last_col),
    .tready (vid.m_axis_tready),
    .ready  (out_ready),
    .tdata  (vid.m_axis_tdata),
    .tkeep  (vid.m_axis_tkeep),
    .tuser  (vid.m_axis_tuser),
    .tlast  (vid.m_axis_tlast),
    .tvalid (vid.m_axis_tvalid)
  );

endmodule
